// File: rtl/acm_pipe_buffer_pkg.sv
// Shared types and constants for the buffered muacm OUT->IN pipe bridge.
package acm_pipe_buffer_pkg;

  localparam logic [7:0] EOL_DEFAULT    = 8'h0A;
  localparam logic [7:0] ASCII_UPPER_LO = 8'h41;
  localparam logic [7:0] ASCII_UPPER_HI = 8'h5A;
  localparam logic [7:0] ASCII_LOWER_LO = 8'h61;
  localparam logic [7:0] ASCII_LOWER_HI = 8'h7A;
  localparam logic [7:0] ASCII_CASE_BIT = 8'h20;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_STREAM,
    ST_LINE,
    ST_DRAIN,
    ST_FLUSH
  } state_t;

  function automatic logic [7:0] swap_case(input logic [7:0] b);
    if ((b >= ASCII_UPPER_LO && b <= ASCII_UPPER_HI) ||
        (b >= ASCII_LOWER_LO && b <= ASCII_LOWER_HI))
      return b ^ ASCII_CASE_BIT;
    return b;
  endfunction

endpackage

// File: rtl/acm_fifo_ram.sv
// Simple dual-port byte RAM with a registered read port, shaped to map onto iCE40 EBR.
module acm_fifo_ram #(
  parameter int DEPTH = 256
) (
  input  logic                     clk_usb,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [7:0]               wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [7:0]               rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk_usb) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/acm_pipe_buffer.sv
// Buffered loopback between the muacm OUT and IN pipes: RAM FIFO, optional case swap,
// and an optional line-buffered release with explicit flush and idle timeout.
module acm_pipe_buffer
  import acm_pipe_buffer_pkg::*;
#(
  parameter int         DEPTH         = 256,
  parameter int         LINE_MODE     = 0,
  parameter logic [7:0] EOL           = EOL_DEFAULT,
  parameter int         CASE_SWAP     = 0,
  parameter int         FLUSH_TIMEOUT = 4800
) (
  input  logic                   clk_usb,
  input  logic                   rst_usb,
  input  logic [7:0]             out_data,
  input  logic                   out_last,
  input  logic                   out_valid,
  output logic                   out_ready,
  output logic [7:0]             in_data,
  output logic                   in_last,
  output logic                   in_valid,
  input  logic                   in_ready,
  output logic                   in_flush_now,
  output logic                   in_flush_time,
  output logic [$clog2(DEPTH):0] level,
  output logic [$clog2(DEPTH):0] lines
);

  localparam int AW   = $clog2(DEPTH);
  localparam int LW   = AW + 1;
  localparam int TO_W = (FLUSH_TIMEOUT > 1) ? $clog2(FLUSH_TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_MAX = TO_W'((FLUSH_TIMEOUT > 0) ? FLUSH_TIMEOUT - 1 : 0);

  state_t          state;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [LW-1:0]   drain_left;
  logic [LW-1:0]   in_ram;
  logic [TO_W-1:0] to_cnt;
  logic            stop;
  logic            push, pop, full, push_eol, pop_eol;
  logic            release_ok, out_load, ram_re, to_run, to_hit;
  logic            vld_p0, eol_p0, last_p0;
  logic [7:0]      ram_q_p0, data_p0;
  logic            eol_p1;
  logic            unused_out_last;

  assign unused_out_last = out_last;

  assign full      = (level == LW'(DEPTH));
  assign out_ready = !full;
  assign push      = out_valid && out_ready;
  assign pop       = in_valid && in_ready;
  assign push_eol  = push && (out_data == EOL);
  assign pop_eol   = pop && eol_p1;
  assign in_flush_time = (LINE_MODE == 0);

  // Bytes still sitting in RAM, not yet in the read register or the output register
  assign in_ram = level - LW'(vld_p0) - LW'(in_valid);

  assign release_ok = (state == ST_STREAM) ||
                      (((state == ST_LINE) || (state == ST_DRAIN)) && !stop);
  assign out_load   = vld_p0 && (!in_valid || in_ready) && release_ok;
  assign ram_re     = (in_ram != '0) && (!vld_p0 || out_load);

  assign to_run = (state == ST_IDLE) && (level != '0) && (lines == '0);
  assign to_hit = (FLUSH_TIMEOUT != 0) && to_run && (to_cnt == TO_MAX);

  acm_fifo_ram #(.DEPTH(DEPTH)) u_ram (
    .clk_usb (clk_usb),
    .we      (push),
    .waddr   (wr_ptr),
    .wdata   (out_data),
    .re      (ram_re),
    .raddr   (rd_ptr),
    .rdata   (ram_q_p0)
  );

  // Stage p0: RAM read register; the EOL test sees the byte before any case swap
  assign data_p0 = (CASE_SWAP != 0) ? swap_case(ram_q_p0) : ram_q_p0;
  assign eol_p0  = (ram_q_p0 == EOL);
  assign last_p0 = (LINE_MODE != 0) &&
                   (eol_p0 || ((state == ST_DRAIN) && (drain_left == LW'(1))));

  always_ff @(posedge clk_usb or posedge rst_usb) begin
    if (rst_usb) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      lines    <= '0;
      vld_p0   <= 1'b0;
      in_valid <= 1'b0;
      in_data  <= '0;
      in_last  <= 1'b0;
      eol_p1   <= 1'b0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + AW'(1);
      if (ram_re) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
      case ({push_eol, pop_eol})
        2'b10:   lines <= lines + LW'(1);
        2'b01:   lines <= lines - LW'(1);
        default: lines <= lines;
      endcase
      if (ram_re)        vld_p0 <= 1'b1;
      else if (out_load) vld_p0 <= 1'b0;
      // Stage p1: output register, refilled on the same edge it drains
      if (out_load) begin
        in_valid <= 1'b1;
        in_data  <= data_p0;
        in_last  <= last_p0;
        eol_p1   <= eol_p0;
      end else if (pop) begin
        in_valid <= 1'b0;
        in_last  <= 1'b0;
        eol_p1   <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_usb or posedge rst_usb) begin
    if (rst_usb) begin
      state        <= ST_IDLE;
      in_flush_now <= 1'b0;
      drain_left   <= '0;
      stop         <= 1'b0;
    end else begin
      in_flush_now <= 1'b0;
      case (state)
        ST_IDLE: begin
          stop <= 1'b0;
          if (LINE_MODE == 0) begin
            state <= ST_STREAM;
          end else if (lines != '0) begin
            state <= ST_LINE;
          end else if (full || to_hit) begin
            state      <= ST_DRAIN;
            drain_left <= level;
          end
        end
        ST_STREAM: state <= ST_STREAM;
        ST_LINE, ST_DRAIN: begin
          if (out_load) begin
            if (last_p0) stop <= 1'b1;
            if (state == ST_DRAIN) drain_left <= drain_left - LW'(1);
          end
          if (pop && in_last) begin
            state        <= ST_FLUSH;
            in_flush_now <= 1'b1;
          end
        end
        ST_FLUSH: state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_usb or posedge rst_usb) begin
    if (rst_usb)                          to_cnt <= '0;
    else if (push || !to_run || to_hit)   to_cnt <= '0;
    else                                  to_cnt <= to_cnt + TO_W'(1);
  end

endmodule
